// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants, state type and helpers for the stream mux arbiter
//
// Purpose: arbitration mode encodings, the packet FSM state type and the
// channel-index width helper used by stream_mux_pick and stream_mux_arb.
// Ports: none (package).

package stream_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_pick.sv
// rtl/stream_mux_pick.sv - combinational round-robin / fixed-priority request picker
//
// Purpose: choose one requester from a request vector.
//   Round-robin: first asserted index searching upward from ptr_i, wrapping.
//   Fixed priority: lowest asserted index (ptr_i ignored).
// Ports:
//   req_i      in  N_CH  request vector
//   ptr_i      in  CH_W  round-robin start index (must be < N_CH)
//   mode_i     in  1     0 = round-robin, 1 = fixed priority
//   gnt_idx_o  out CH_W  granted index (0 when nothing requested)
//   gnt_vld_o  out 1     at least one request asserted

module stream_mux_pick
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  input  logic            mode_i,
  output logic [CH_W-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  always_comb begin
    int          idx;
    logic [N_CH-1:0] shifted;
    idx       = 0;
    shifted   = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = mode_i ? i : int'(ptr_i) + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      // Shift instead of a variable bit-select so the index width never
      // has to match the vector width (N_CH need not be a power of two).
      shifted = req_i >> idx;
      if (!gnt_vld_o && shifted[0]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel packet-locking stream mux with registered output
//
// Purpose: arbitrate N_CH valid/ready input streams onto one registered
// output stream, holding each grant from first beat to last beat and tagging
// every output beat with its source channel.
// Ports:
//   clk_i        in  1            clock, rising edge
//   rst_ni       in  1            asynchronous active-low reset
//   in_valid_i   in  N_CH         per-channel beat valid
//   in_data_i    in  N_CH*DATA_W  channel k data at [k*DATA_W +: DATA_W]
//   in_last_i    in  N_CH         per-channel last beat of packet
//   in_ready_o   out N_CH         per-channel beat accept
//   out_valid_o  out 1            output beat valid
//   out_data_o   out DATA_W       output data
//   out_last_o   out 1            output last beat
//   out_ch_o     out CH_W         source channel of output beat
//   out_ready_i  in  1            consumer accepts output beat

module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = MODE_RR,
  localparam int CH_W  = ch_width(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_CH-1:0]        in_valid_i,
  input  logic [N_CH*DATA_W-1:0] in_data_i,
  input  logic [N_CH-1:0]        in_last_i,
  output logic [N_CH-1:0]        in_ready_o,
  output logic                   out_valid_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic                   out_last_o,
  output logic [CH_W-1:0]        out_ch_o,
  input  logic                   out_ready_i
);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic [CH_W-1:0]   pick_idx;
  logic              pick_vld;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_ok;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              out_free;
  logic              accept;

  stream_mux_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req_i     (in_valid_i),
    .ptr_i     (ptr_q),
    .mode_i    (MODE == MODE_FIXED),
    .gnt_idx_o (pick_idx),
    .gnt_vld_o (pick_vld)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign out_free = !out_valid_q || out_ready_i;

  // While locked the owner keeps the grant even when its valid drops.
  assign sel_ch = (state_q == ST_LOCKED) ? lock_ch_q : pick_idx;
  assign sel_ok = (state_q == ST_LOCKED) || pick_vld;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_ch == CH_W'(k)) begin
        sel_valid = in_valid_i[k];
        sel_data  = in_data_i[k*DATA_W +: DATA_W];
        sel_last  = in_last_i[k];
      end
    end
  end

  // Gated by rst_ni so no channel sees ready while reset is held.
  always_comb begin
    in_ready_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      in_ready_o[k] = rst_ni && out_free && sel_ok && (sel_ch == CH_W'(k));
    end
  end

  assign accept = rst_ni && out_free && sel_ok && sel_valid;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_ch_d    = sel_ch;
      if (sel_last) begin
        state_d = ST_IDLE;
        if (MODE == MODE_RR) begin
          ptr_d = (sel_ch == CH_W'(N_CH - 1)) ? '0 : sel_ch + 1'b1;
        end
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = sel_ch;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - scoreboard bench for stream_mux_arb (round-robin and fixed-priority)

module tb_stream_mux_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready, fx_in_ready;
  logic           out_valid, out_last, fx_out_valid, fx_out_last;
  logic [W-1:0]   out_data, fx_out_data;
  logic [1:0]     out_ch, fx_out_ch;
  logic           out_ready = 1'b0;

  always #5 clk = ~clk;

  stream_mux_arb #(.N_CH(N), .DATA_W(W), .MODE(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_ready_o(in_ready), .out_valid_o(out_valid),
    .out_data_o(out_data), .out_last_o(out_last), .out_ch_o(out_ch),
    .out_ready_i(out_ready)
  );

  stream_mux_arb #(.N_CH(N), .DATA_W(W), .MODE(1)) dut_fx (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_last_i(in_last), .in_ready_o(fx_in_ready), .out_valid_o(fx_out_valid),
    .out_data_o(fx_out_data), .out_last_o(fx_out_last), .out_ch_o(fx_out_ch),
    .out_ready_i(out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Producer packet queues: bit 8 = last, bits 7:0 = data.
  logic [8:0]  pq [N][$];
  // Expected output beats: {ch[1:0], last, data}.
  logic [10:0] expq [$];
  int log_ch [$];
  int log_data [$];
  int log_cyc [$];

  int       valid_pct = 100;
  int       ready_pct = 100;
  bit [N-1:0] force_off = '0;

  // Reference model: packet owner, round-robin pointer, output slot occupancy.
  bit m_locked;
  bit m_full;
  int m_lock_ch;
  int m_ptr;

  logic [10:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_output_beat", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        chk("out_ch", int'(out_ch), int'(mon_e[10:9]));
        chk("out_data", int'(out_data), int'(mon_e[7:0]));
        chk("out_last", int'(out_last), int'(mon_e[8]));
        log_ch.push_back(int'(out_ch));
        log_data.push_back(int'(out_data));
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    int         g;
    int         c;
    bit         free;
    bit         acc;
    logic [N-1:0] exp_rdy;
    logic [8:0] d;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (pq[k].size() > 0 && !force_off[k] && $urandom_range(99) < valid_pct) begin
        in_valid[k]       = 1'b1;
        in_data[k*W +: W] = pq[k][0][7:0];
        in_last[k]        = pq[k][0][8];
      end else begin
        in_valid[k]       = 1'b0;
        in_data[k*W +: W] = 8'($urandom);
        in_last[k]        = 1'($urandom);
      end
    end
    out_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    free = !m_full || out_ready;
    g = -1;
    if (m_locked) begin
      g = m_lock_ch;
    end else begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (g < 0 && in_valid[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0 && free) exp_rdy[g] = 1'b1;
    acc = (g >= 0) && free && in_valid[g];
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("out_valid", int'(out_valid), int'(m_full));
    if (acc) begin
      d = pq[g].pop_front();
      expq.push_back({2'(g), d});
      if (d[8]) begin
        m_locked = 1'b0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked  = 1'b1;
        m_lock_ch = g;
      end
    end
    m_full = acc ? 1'b1 : (out_ready ? 1'b0 : m_full);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = {N{8'h5A}};
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) pq[k].delete();
    expq.delete();
    log_ch.delete();
    log_data.delete();
    log_cyc.delete();
    m_locked  = 1'b0;
    m_full    = 1'b0;
    m_lock_ch = 0;
    m_ptr     = 0;
    force_off = '0;
    valid_pct = 100;
    ready_pct = 100;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_fx_in_ready", int'(fx_in_ready), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    int pend;
    n = 0;
    pend = 1;
    while (pend != 0 && n < budget) begin
      step();
      n++;
      pend = expq.size();
      for (int k = 0; k < N; k++) pend += pq[k].size();
    end
    chk("drain_pending_at_timeout", pend, 0);
  endtask

  task automatic chk_log(input string name, input int idx, input int act_ch, input int act_data,
                         input int exp_ch, input int exp_data);
    chk({name, "_ch"}, act_ch, exp_ch);
    chk({name, "_data"}, act_data, exp_data);
    if (idx < 0) chk({name, "_index"}, idx, 0);
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
  int lk_data [4] = '{8'h10, 8'h11, 8'h12, 8'h77};
  int lk_ch [4] = '{2, 2, 2, 0};
  int wr_ch [3] = '{2, 3, 1};

  initial begin
    // Reset mid-packet: two of three ch1 beats, then reset; ch2 single beat after.
    do_reset();
    pq[1].push_back({1'b0, 8'h21});
    pq[1].push_back({1'b0, 8'h22});
    pq[1].push_back({1'b1, 8'h23});
    step();
    step();
    do_reset();
    pq[2].push_back({1'b1, 8'h5A});
    drain(20);
    chk("rstmid_count", log_ch.size(), 1);
    if (log_ch.size() >= 1) chk_log("rstmid", 0, log_ch[0], log_data[0], 2, 8'h5A);

    // Round-robin fairness: all four channels hold single-beat packets.
    do_reset();
    for (int k = 0; k < N; k++) begin
      pq[k].push_back({1'b1, 8'(8'h40 + k)});
      pq[k].push_back({1'b1, 8'(8'h50 + k)});
    end
    drain(30);
    chk("rr_count", log_ch.size(), 8);
    if (log_ch.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("rr_seq_ch", log_ch[i], rr_exp[i]);
      for (int i = 1; i < 6; i++) chk("rr_back_to_back", log_cyc[i] - log_cyc[i-1], 1);
    end

    // Packet lock with a two-cycle gap from the owner while ch0 waits.
    do_reset();
    pq[2].push_back({1'b0, 8'h10});
    pq[2].push_back({1'b0, 8'h11});
    pq[2].push_back({1'b1, 8'h12});
    pq[0].push_back({1'b1, 8'h77});
    force_off = 4'b0001;
    step();
    force_off = 4'b0100;
    step();
    chk("lock_gap_ch0_ready", int'(in_ready[0]), 0);
    step();
    chk("lock_gap_ch0_ready", int'(in_ready[0]), 0);
    force_off = '0;
    drain(20);
    chk("lock_count", log_ch.size(), 4);
    if (log_ch.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk_log("lock", i, log_ch[i], log_data[i], lk_ch[i], lk_data[i]);
    end

    // Backpressure: 0xA5 held for three stalled cycles, then drain and reload together.
    do_reset();
    pq[0].push_back({1'b1, 8'hA5});
    pq[1].push_back({1'b1, 8'h3C});
    force_off = 4'b0010;
    step();
    force_off = '0;
    ready_pct = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", int'(out_data), 8'hA5);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    ready_pct = 100;
    drain(20);
    chk("bp_count", log_data.size(), 2);
    if (log_data.size() >= 2) begin
      chk("bp_first", log_data[0], 8'hA5);
      chk("bp_second", log_data[1], 8'h3C);
      chk("bp_no_bubble", log_cyc[1] - log_cyc[0], 1);
    end

    // Wrap-around: after a ch2 packet the pointer is 3; ch1 and ch3 compete.
    do_reset();
    pq[2].push_back({1'b1, 8'h33});
    drain(20);
    pq[1].push_back({1'b1, 8'h44});
    pq[3].push_back({1'b1, 8'h55});
    drain(20);
    chk("wrap_count", log_ch.size(), 3);
    if (log_ch.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("wrap_seq_ch", log_ch[i], wr_ch[i]);
    end

    // Fixed priority instance: ch0 and ch3 both valid, only ch0 may be served.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pq[0].push_back({1'b1, 8'(i)});
      pq[3].push_back({1'b1, 8'(8'h80 + i)});
    end
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fx_ch3_ready", int'(fx_in_ready[3]), 0);
      chk("fx_ch0_ready", int'(fx_in_ready[0]), int'(in_valid[0]));
      if (fx_out_valid) chk("fx_out_ch", int'(fx_out_ch), 0);
    end
    drain(60);

    // Randomised traffic: multi-beat packets, random valid gaps and backpressure.
    for (int round = 0; round < 2; round++) begin
      do_reset();
      valid_pct = (round == 0) ? 70 : 90;
      ready_pct = (round == 0) ? 60 : 85;
      for (int k = 0; k < N; k++) begin
        for (int p = 0; p < 6; p++) begin
          int len;
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++) pq[k].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      drain(3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel streaming multiplexer with arbitration, the registered successor to the combinational select mux. Each input channel offers valid/data/last beats; the block picks one channel per packet (round-robin or fixed priority), holds that grant until the packet's last beat, and drives a single registered valid/ready output stream tagged with the source channel index. It sits between multiple producers and one shared consumer.

## Interface
- N_CH, 4, number of input channels (>=1)
- DATA_W, 8, data width per channel
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- CH_W (localparam), max(1, clog2(N_CH)), channel index width

- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- IN_VALID  in  N_CH  per-channel beat valid
- IN_DATA  in  N_CH*DATA_W  channel k data at bits [k*DATA_W +: DATA_W]
- IN_LAST  in  N_CH  per-channel last beat of packet
- IN_READY  out  N_CH  per-channel beat accepted this cycle when IN_VALID[k] is also high
- OUT_VALID  out  1  output beat valid
- OUT_DATA  out  DATA_W  output data
- OUT_LAST  out  1  output last beat
- OUT_CH  out  CH_W  source channel of the output beat
- OUT_READY  in  1  consumer accepts output beat

## Operation
- States: IDLE (no packet in progress), LOCKED (packet from lock_ch in progress).
- Output register free when OUT_VALID=0 or OUT_READY=1 (drain and load in the same cycle allowed).
- IDLE: arbiter picks g among asserted IN_VALID. RR: first asserted index searching upward from ptr, wrapping at N_CH-1 -> 0. Fixed: lowest asserted index. IN_READY[g]=1 iff output register free; all other IN_READY=0.
- Accepted beat with IN_LAST=0 in IDLE -> LOCKED, lock_ch=g. Accepted beat with IN_LAST=1 -> stay IDLE, packet done.
- LOCKED: only lock_ch is eligible; IN_READY[lock_ch]=1 iff output register free. Other channels wait regardless of their valid. IN_VALID[lock_ch] dropping mid-packet stalls; the lock is not released. Accepted beat with IN_LAST=1 -> IDLE.
- Packet done (RR only): ptr <= (done channel + 1) mod N_CH. Fixed mode never uses ptr.
- No IN_VALID asserted in IDLE: all IN_READY=0, no state change.
- OUT_VALID=1 and OUT_READY=0: OUT_DATA/OUT_LAST/OUT_CH held stable, no input accepted.
- N_CH=1: arbiter degenerates to channel 0; OUT_CH constant 0.
- Reset (any time, including mid-packet): state IDLE, ptr 0, output register cleared; in-flight beat discarded.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_CH=0, IN_READY all 0 while RST_N=0.
- IN_READY is combinational from state, ptr, IN_VALID, OUT_VALID, OUT_READY; no combinational path IN_DATA -> outputs.
- Latency: beat accepted at edge t appears on OUT_* after edge t (one cycle).
- Throughput: one beat per cycle with OUT_READY held high, including back-to-back packets from different channels (no idle bubble between a LAST beat and the next grant).
- Arbitration decision at packet start uses the ptr value updated at the previous packet's LAST acceptance edge.

## Structure
- Package stream_mux_pkg: MODE_RR=0, MODE_FIXED=1 constants; state enum {ST_IDLE, ST_LOCKED}.
- Sub-module stream_mux_pick: combinational picker (request vector, ptr, mode) -> grant index + grant valid; reused by other arbiters.
- Top holds state, lock_ch, ptr, output register.

## Test plan
- Reset mid-packet: ch1 sends 2 of 3 beats, assert RST_N=0 -> all outputs 0, IN_READY=0; after release, ch2 single beat 0x5A appears with OUT_CH=2, ch1 remainder not forwarded as locked.
- RR fairness, N_CH=4, all channels hold single-beat packets, OUT_READY=1 -> OUT_CH sequence 0,1,2,3,0,1 on consecutive cycles.
- Fixed priority, MODE=1, ch0 and ch3 always valid -> only ch0 forwarded; ch3 IN_READY stays 0.
- Packet lock: ch2 sends 0x10,0x11,0x12(last) while ch0 valid -> output 0x10,0x11,0x12 all OUT_CH=2, then ch0 beat; ch2 gap of 2 cycles mid-packet does not release lock.
- Backpressure: OUT_READY=0 for 3 cycles with OUT_VALID=1, data 0xA5 -> OUT_DATA stays 0xA5, all IN_READY=0; OUT_READY=1 -> next beat loaded same cycle 0xA5 drains.
- Wrap-around: RR ptr at 3 after ch2 packet, only ch1 and ch3 valid -> ch3 granted, then ch1.
